fp_exec_seq: RTL and testbench

- Sequencing and result-register stage wrapped around the combinational FP units (add, mul, div, sqrt) of the single-precision FP datapath.
- Accepts one FP operation per transaction over a valid/ready handshake and drives registered, stable operands to the units.
- Waits a per-op settle count to cover deep combinational paths (sqrt is 3 div + 3 add + 2 mul deep), captures result and flags, and presents them downstream over valid/ready.
- Maintains sticky RISC-V fflags.

---
 rtl/fp_exec_pkg.sv | 30 +++
 rtl/fp_flag_gen.sv | 65 ++++++
 rtl/fp_exec_seq.sv | 161 ++++++++++++++++
 tb/tb_fp_exec_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_exec_pkg.sv
// Shared constants for the FP execution sequencer: op-codes, FSM states,
// fflags bit positions and the canonical quiet NaN.
package fp_exec_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [4:0]  NV_MASK = 5'b10000;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_SQRT;
    endfunction

endpackage

// File: rtl/fp_flag_gen.sv
// Combinational result selection and IEEE flag derivation for the captured
// op, including the divide-by-zero and sqrt-exception overrides.
module fp_flag_gen
    import fp_exec_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] res_add,
    input  logic [31:0] res_mul,
    input  logic [31:0] res_div,
    input  logic [31:0] res_sqrt,
    input  logic        sqrt_exception,
    input  logic        sqrt_overflow,
    input  logic        sqrt_underflow,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    logic a_mag_zero;
    logic b_mag_zero;
    logic a_exp_max;
    logic b_exp_max;

    assign a_mag_zero = (op_a[30:0] == 31'd0);
    assign b_mag_zero = (op_b[30:0] == 31'd0);
    assign a_exp_max  = (op_a[30:23] == 8'hFF);
    assign b_exp_max  = (op_b[30:23] == 8'hFF);

    always_comb begin
        result = QNAN;
        flags  = '0;
        case (op)
            OP_ADD, OP_SUB: result = res_add;
            OP_MUL:         result = res_mul;
            OP_DIV:         result = res_div;
            OP_SQRT:        result = res_sqrt;
            default:        result = QNAN;
        endcase

        if (op == OP_SQRT) begin
            flags[FLAG_NV] = sqrt_exception;
            flags[FLAG_OF] = sqrt_overflow;
            flags[FLAG_UF] = sqrt_underflow;
            if (sqrt_exception) begin
                result = QNAN;
            end
        end else if (op == OP_DIV && b_mag_zero) begin
            // The divider's own output for a zero divisor is not trusted.
            if (!a_mag_zero) begin
                flags[FLAG_DZ] = 1'b1;
                result         = {op_a[31] ^ op_b[31], 8'hFF, 23'd0};
            end else begin
                flags[FLAG_NV] = 1'b1;
                result         = QNAN;
            end
        end else if (op_is_legal(op)) begin
            // Infinity produced from finite exponents means the unit overflowed.
            flags[FLAG_OF] = (result[30:23] == 8'hFF) && !a_exp_max && !b_exp_max;
        end else begin
            flags[FLAG_NV] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_exec_seq.sv
// Sequencer around the combinational FP units: holds operands stable for a
// per-op settle time, captures result/flags and keeps sticky fflags.
module fp_exec_seq
    import fp_exec_pkg::*;
#(
    parameter int SETTLE_ADD  = 2,
    parameter int SETTLE_MUL  = 2,
    parameter int SETTLE_DIV  = 4,
    parameter int SETTLE_SQRT = 12,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] res_add,
    input  logic [31:0] res_mul,
    input  logic [31:0] res_div,
    input  logic [31:0] res_sqrt,
    input  logic        sqrt_exception,
    input  logic        sqrt_overflow,
    input  logic        sqrt_underflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags,
    input  logic        fflags_clr,
    output logic [4:0]  fflags
);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        op_reg;
    logic [31:0]       op_a_reg;
    logic [31:0]       op_b_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic [31:0]       out_result_reg;
    logic [4:0]        out_flags_reg;
    logic [4:0]        fflags_reg;
    logic [4:0]        fflags_next;

    logic [31:0]       gen_result;
    logic [4:0]        gen_flags;
    logic              illegal_accept;
    logic              settle_done;

    // A zero settle count still needs one cycle for the operand registers.
    function automatic logic [CNT_W-1:0] settle_load(input logic [2:0] op);
        int s;
        case (op)
            OP_ADD, OP_SUB: s = SETTLE_ADD;
            OP_MUL:         s = SETTLE_MUL;
            OP_DIV:         s = SETTLE_DIV;
            OP_SQRT:        s = SETTLE_SQRT;
            default:        s = 1;
        endcase
        if (s < 1) begin
            s = 1;
        end
        return CNT_W'(s - 1);
    endfunction

    fp_flag_gen u_flag_gen (
        .op             (op_reg),
        .op_a           (op_a_reg),
        .op_b           (op_b_reg),
        .res_add        (res_add),
        .res_mul        (res_mul),
        .res_div        (res_div),
        .res_sqrt       (res_sqrt),
        .sqrt_exception (sqrt_exception),
        .sqrt_overflow  (sqrt_overflow),
        .sqrt_underflow (sqrt_underflow),
        .result         (gen_result),
        .flags          (gen_flags)
    );

    assign illegal_accept = (state_reg == ST_IDLE) && in_valid && !op_is_legal(in_op);
    assign settle_done    = (state_reg == ST_SETTLE) && (cnt_reg == '0);

    // Clear applies before the OR so a same-cycle capture survives the clear.
    always_comb begin
        fflags_next = fflags_clr ? 5'd0 : fflags_reg;
        if (illegal_accept) begin
            fflags_next = fflags_next | NV_MASK;
        end else if (settle_done) begin
            fflags_next = fflags_next | gen_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            op_reg         <= OP_ADD;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_flags_reg  <= '0;
            fflags_reg     <= '0;
        end else begin
            fflags_reg <= fflags_next;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg       <= in_op;
                        op_a_reg     <= in_a;
                        op_b_reg     <= (in_op == OP_SUB) ? {~in_b[31], in_b[30:0]} : in_b;
                        in_ready_reg <= 1'b0;
                        if (op_is_legal(in_op)) begin
                            cnt_reg   <= settle_load(in_op);
                            state_reg <= ST_SETTLE;
                        end else begin
                            out_result_reg <= QNAN;
                            out_flags_reg  <= NV_MASK;
                            out_valid_reg  <= 1'b1;
                            state_reg      <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == '0) begin
                        out_result_reg <= gen_result;
                        out_flags_reg  <= gen_flags;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign op_a       = op_a_reg;
    assign op_b       = op_b_reg;
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_flags  = out_flags_reg;
    assign fflags     = fflags_reg;

endmodule

// File: tb/tb_fp_exec_seq.sv
// Directed bench for fp_exec_seq: the FP units are modelled as constant
// result inputs; every transaction prints one line.
module tb_fp_exec_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] res_add;
    logic [31:0] res_mul;
    logic [31:0] res_div;
    logic [31:0] res_sqrt;
    logic        sqrt_exception;
    logic        sqrt_overflow;
    logic        sqrt_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic        fflags_clr;
    logic [4:0]  fflags;

    int tests = 0;
    int fails = 0;
    int lat;

    always #5 clk = ~clk;

    fp_exec_seq dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_a           (in_a),
        .in_b           (in_b),
        .op_a           (op_a),
        .op_b           (op_b),
        .res_add        (res_add),
        .res_mul        (res_mul),
        .res_div        (res_div),
        .res_sqrt       (res_sqrt),
        .sqrt_exception (sqrt_exception),
        .sqrt_overflow  (sqrt_overflow),
        .sqrt_underflow (sqrt_underflow),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_flags      (out_flags),
        .fflags_clr     (fflags_clr),
        .fflags         (fflags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request for exactly one edge; only used while the DUT is idle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, bounded at 40.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
        res_add = '0; res_mul = '0; res_div = '0; res_sqrt = '0;
        sqrt_exception = 1'b0; sqrt_overflow = 1'b0; sqrt_underflow = 1'b0;
        out_ready = 1'b0; fflags_clr = 1'b0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_out_result", out_result, 0);
        check("rst_fflags", fflags, 0);
        rst = 1'b0;
        step();

        // ADD 1.0 + 2.0
        res_add = 32'h4040_0000;
        issue(3'd0, 32'h3F80_0000, 32'h4000_0000);
        check("add_in_ready_busy", in_ready, 0);
        check("add_op_a", op_a, 32'h3F80_0000);
        check("add_op_b", op_b, 32'h4000_0000);
        wait_valid(lat);
        check("add_latency", lat, 2);
        check("add_result", out_result, 32'h4040_0000);
        check("add_flags", out_flags, 5'b00000);
        $display("[TB] ADD  lat=%0d result=%h flags=%b", lat, out_result, out_flags);
        take_result();
        check("add_exit_valid", out_valid, 0);
        check("add_exit_ready", in_ready, 1);

        // SUB 3.0 - 1.0: op_b carries the inverted sign through settle and DONE
        res_add = 32'h4000_0000;
        issue(3'd1, 32'h4040_0000, 32'h3F80_0000);
        check("sub_op_b_c0", op_b, 32'hBF80_0000);
        check("sub_op_a_c0", op_a, 32'h4040_0000);
        check("sub_valid_c0", out_valid, 0);
        step();
        check("sub_op_b_c1", op_b, 32'hBF80_0000);
        check("sub_op_a_c1", op_a, 32'h4040_0000);
        check("sub_valid_c1", out_valid, 0);
        step();
        check("sub_valid_c2", out_valid, 1);
        check("sub_op_b_c2", op_b, 32'hBF80_0000);
        check("sub_result", out_result, 32'h4000_0000);
        $display("[TB] SUB  result=%h flags=%b", out_result, out_flags);
        take_result();

        // SQRT of -4.0: unit raises exception, result forced to qNaN
        res_sqrt = 32'hFFC0_0000;
        sqrt_exception = 1'b1;
        issue(3'd4, 32'hC080_0000, 32'h0);
        wait_valid(lat);
        check("sqrt_latency", lat, 12);
        check("sqrt_result", out_result, 32'h7FC0_0000);
        check("sqrt_flags", out_flags, 5'b10000);
        check("sqrt_fflags", fflags, 5'b10000);
        $display("[TB] SQRT lat=%0d result=%h flags=%b fflags=%b", lat, out_result, out_flags, fflags);
        take_result();
        sqrt_exception = 1'b0;

        // DIV 1.0 / 0.0 -> +inf, DZ
        res_div = 32'h1234_5678;
        issue(3'd3, 32'h3F80_0000, 32'h0000_0000);
        wait_valid(lat);
        check("div_dz_latency", lat, 4);
        check("div_dz_result", out_result, 32'h7F80_0000);
        check("div_dz_flags", out_flags, 5'b01000);
        check("div_dz_fflags", fflags, 5'b11000);
        $display("[TB] DIV  lat=%0d result=%h flags=%b fflags=%b", lat, out_result, out_flags, fflags);
        take_result();

        // DIV 0/0 -> qNaN, NV; then hold out_ready low for 5 cycles
        issue(3'd3, 32'h0000_0000, 32'h0000_0000);
        wait_valid(lat);
        check("div_nv_result", out_result, 32'h7FC0_0000);
        check("div_nv_flags", out_flags, 5'b10000);
        check("div_nv_fflags", fflags, 5'b11000);
        $display("[TB] DIV0 lat=%0d result=%h flags=%b fflags=%b", lat, out_result, out_flags, fflags);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", out_result, 32'h7FC0_0000);
            check("hold_flags", out_flags, 5'b10000);
        end

        // New request presented on the result-acceptance edge must wait a cycle
        res_mul  = 32'h40C0_0000;
        in_valid = 1'b1; in_op = 3'd2; in_a = 32'h4000_0000; in_b = 32'h4040_0000;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("mul_noaccept_ready", in_ready, 1);
        check("mul_noaccept_op_a", op_a, 32'h0000_0000);
        check("mul_noaccept_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("mul_accept_ready", in_ready, 0);
        check("mul_accept_op_a", op_a, 32'h4000_0000);
        wait_valid(lat);
        check("mul_latency", lat, 2);
        check("mul_result", out_result, 32'h40C0_0000);
        check("mul_flags", out_flags, 5'b00000);
        $display("[TB] MUL  lat=%0d result=%h flags=%b", lat, out_result, out_flags);
        take_result();

        // MUL overflow, with fflags_clr pulsed exactly on the capture edge
        res_mul = 32'h7F80_0000;
        issue(3'd2, 32'h7F00_0000, 32'h4000_0000);
        step();
        check("of_pre_fflags", fflags, 5'b11000);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("of_valid", out_valid, 1);
        check("of_flags", out_flags, 5'b00100);
        check("of_fflags_clr", fflags, 5'b00100);
        $display("[TB] MULO result=%h flags=%b fflags=%b", out_result, out_flags, fflags);
        fflags_clr = 1'b1;
        take_result();
        fflags_clr = 1'b0;
        check("clr_only_fflags", fflags, 5'b00000);

        // ADD with an infinite operand: infinite result is not an overflow
        res_add = 32'h7F80_0000;
        issue(3'd0, 32'h7F80_0000, 32'h3F80_0000);
        wait_valid(lat);
        check("inf_result", out_result, 32'h7F80_0000);
        check("inf_flags", out_flags, 5'b00000);
        check("inf_fflags", fflags, 5'b00000);
        $display("[TB] ADDI result=%h flags=%b", out_result, out_flags);
        take_result();

        // Reset in the middle of a SQRT settle aborts it
        sqrt_exception = 1'b1;
        issue(3'd4, 32'hC080_0000, 32'h0);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_fflags", fflags, 5'b00000);
        check("abort_result", out_result, 32'h0);
        for (int i = 0; i < 15; i++) step();
        check("abort_no_result", out_valid, 0);
        check("abort_no_flags", fflags, 5'b00000);
        $display("[TB] RST  mid-SQRT in_ready=%b out_valid=%b fflags=%b", in_ready, out_valid, fflags);
        sqrt_exception = 1'b0;

        // Illegal op 6: result visible right after the edge that samples it
        issue(3'd6, 32'h3F80_0000, 32'h3F80_0000);
        check("illegal_valid", out_valid, 1);
        check("illegal_result", out_result, 32'h7FC0_0000);
        check("illegal_flags", out_flags, 5'b10000);
        check("illegal_fflags", fflags, 5'b10000);
        $display("[TB] ILL  result=%h flags=%b fflags=%b", out_result, out_flags, fflags);
        take_result();
        check("illegal_exit_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
